acceptance_filter: RTL and testbench
====================================

// Module: acceptance_filter
// PURPOSE
// - Receive-path acceptance filter of the CAN controller. Sits downstream of the acceptance
//   code and acceptance mask registers, and upstream of the receive buffer write logic.
// - Collects the destuffed identifier, RTR and IDE bits from the bit-stream processor.
// - On a successful frame end, compares the identifier against code/mask and issues a
//   one-cycle accept strobe that qualifies the receive-buffer write.
// PARAMETERS
// - IDW_EXT  29  extended identifier width (base 11 + extension 18); fixed by CAN 2.0B.
// - IDW_STD  11  standard identifier width; fixed by CAN 2.0A.
// PORTS
// - clk        in   1   system clock, all logic on rising edge
// - rst        in   1   synchronous reset, active low
// - sof        in   1   1-cycle pulse: start of frame detected
// - bit_valid  in   1   1-cycle strobe: rx_bit holds next destuffed frame bit
// - rx_bit     in   1   destuffed received bit
// - rx_ok      in   1   1-cycle pulse: frame received without error (after EOF)
// - rx_err     in   1   1-cycle pulse: frame aborted by error
// - acccode1   in   16  acceptance code low word (ID[15:0])
// - acccode2   in   16  acceptance code high word ([12:0]=ID[28:16], [13]=RTR)
// - accmask1   in   16  acceptance mask low word, bit=1 -> bit must match
// - accmask2   in   16  acceptance mask high word, same layout as acccode2
// - accept     out  1   1-cycle pulse: frame passed filter
// - rx_id      out  29  captured identifier; standard frames left-aligned in [28:18], [17:0]=0
// - rx_ide     out  1   captured IDE bit
// - rx_rtr     out  1   captured RTR bit (RTR of ext frame, not SRR)
// - filt_busy  out  1   1 while state != IDLE
// BEHAVIOUR
// - Reset: accept=0, rx_id=0, rx_ide=0, rx_rtr=0, filt_busy=0; state=IDLE; bit counter=0.
// - Bits are consumed only when bit_valid=1. The first bit after sof is ID28 (MSB first).
// - State IDLE: on sof -> BASE, clear counter and rx_id.
// - State BASE: shift 11 bits into rx_id[28:18]; after the 11th bit -> SRR.
// - State SRR: next bit -> rx_rtr (provisional) -> IDE.
// - State IDE: next bit -> rx_ide.
//   - IDE=0: -> WAIT.
//   - IDE=1: -> EXT, counter cleared.
// - State EXT: shift 18 bits into rx_id[17:0]; after the 18th bit -> RTR.
// - State RTR: next bit overwrites rx_rtr -> WAIT.
// - State WAIT: ignore bit_valid.
//   - On rx_ok: evaluate the filter, then go to IDLE.
//   - On rx_err: go to IDLE with no accept.
// - Filter evaluation, combinational at the rx_ok cycle, registered into accept:
//   - match = &(~({accmask2[12:0],accmask1} & ({acccode2[12:0],acccode1} ^ rx_id)))
//   - Standard frame: only mask bits [28:18] take part; ID[17:0] are treated as don't-care.
// - Latency: accept is high in the cycle after the rx_ok cycle, for exactly 1 cycle.
// - Code/mask registers are sampled only in the rx_ok cycle. CPU writes during a frame affect
//   only a frame whose rx_ok comes after the write.
// - rx_id, rx_ide and rx_rtr hold their values until the next sof.
// - Boundary cases:
//   - rx_err in any non-IDLE state -> IDLE, accept stays 0, captured fields keep partial values.
//   - rx_ok in any state other than WAIT (truncated header) -> IDLE, no accept.
//   - sof in any non-IDLE state restarts at BASE. Partial data is discarded.
//   - sof and rx_ok in the same cycle in WAIT: evaluate and issue accept, then enter BASE.
//   - sof and rx_err in the same cycle: enter BASE.
//   - bit_valid in the same cycle as sof is ignored.
//   - All-zero masks: every complete frame is accepted.
//   - Reset mid-frame: all outputs return to reset values in the next cycle.
// CONFIGURATION
// - ACCF_RTR_FILTER_EN defined:
//   - The RTR bit takes part in the match: requires ~(accmask2[13] & (acccode2[13]^rx_rtr)).
// - ACCF_RTR_FILTER_EN undefined:
//   - The RTR bit and code/mask bit 13 are ignored.
//   - accmask2[15:13] and acccode2[15:13] are unused.
// TESTING
// - Standard frame, ID=0x123, masks all 1, code ID[28:18]=0x123, rx_ok
//   -> accept=1 one cycle after rx_ok; rx_id=0x123<<18; rx_ide=0.
// - Extended frame, ID=0x1ABCDEF0, code=0x1ABCDEF1, mask=0x1FFFFFFE
//   -> accept=1. Same frame with mask=0x1FFFFFFF -> accept stays 0.
// - Extended frame completes, then rx_err instead of rx_ok
//   -> accept=0, state IDLE, filt_busy=0.
// - sof after 5 base bits, then a full std frame with ID=0x7FF, mask 0 -> accept=1, rx_id[28:18]=0x7FF.
// - rst=0 asserted while in EXT state
//   -> next cycle all outputs are 0 and filt_busy=0. The following frame is filtered normally.
// - With ACCF_RTR_FILTER_EN: std ID=0x055, RTR=1, code2[13]=0, mask2[13]=1 -> accept=0.
//   Without the macro, the same stimulus -> accept=1.

Source files
------------

// File: rtl/acceptance_filter.sv
// CAN receive acceptance filter: captures ID/IDE/RTR and strobes accept on rx_ok.
// Optional ACCF_RTR_FILTER_EN adds the RTR bit to the code/mask match.
module acceptance_filter (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        bit_valid,
  input  logic        rx_bit,
  input  logic        rx_ok,
  input  logic        rx_err,
  input  logic [15:0] acccode1,
  input  logic [15:0] acccode2,
  input  logic [15:0] accmask1,
  input  logic [15:0] accmask2,
  output logic        accept,
  output logic [28:0] rx_id,
  output logic        rx_ide,
  output logic        rx_rtr,
  output logic        filt_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_SRR,
    S_IDE,
    S_EXT,
    S_RTR,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [28:0] code;
  logic [28:0] mask;
  logic        match;
  logic        abort;
  logic        unused_bits;

  assign filt_busy   = (state != S_IDLE);
  assign abort       = filt_busy && (rx_ok || rx_err);
  assign unused_bits = ^{acccode2[15:13], accmask2[15:13]};

  // Standard frames leave ID[17:0] out of the compare.
  always_comb begin
    code = {acccode2[12:0], acccode1};
    mask = {accmask2[12:0], accmask1};
    if (!rx_ide)
      mask[17:0] = '0;
    match = ~|(mask & (code ^ rx_id));
`ifdef ACCF_RTR_FILTER_EN
    match = match & ~(accmask2[13] & (acccode2[13] ^ rx_rtr));
`endif
  end

  always_comb begin
    state_nxt = state;
    if (sof) begin
      state_nxt = S_BASE;
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else if (bit_valid) begin
      unique case (state)
        S_BASE:  if (cnt == 5'd10) state_nxt = S_SRR;
        S_SRR:   state_nxt = S_IDE;
        S_IDE:   state_nxt = rx_bit ? S_EXT : S_WAIT;
        S_EXT:   if (cnt == 5'd17) state_nxt = S_RTR;
        S_RTR:   state_nxt = S_WAIT;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (sof)
        cnt <= '0;
      else if (bit_valid && !abort) begin
        unique case (state)
          S_BASE:  cnt <= cnt + 5'd1;
          S_IDE:   cnt <= '0;
          S_EXT:   cnt <= cnt + 5'd1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      accept <= 1'b0;
      rx_id  <= '0;
      rx_ide <= 1'b0;
      rx_rtr <= 1'b0;
    end else begin
      accept <= (state == S_WAIT) && rx_ok && !rx_err && match;
      if (sof) begin
        rx_id <= '0;
      end else if (bit_valid && !abort) begin
        unique case (state)
          S_BASE:  rx_id[28:18] <= {rx_id[27:18], rx_bit};
          S_SRR:   rx_rtr <= rx_bit;
          S_IDE:   rx_ide <= rx_bit;
          S_EXT:   rx_id[17:0] <= {rx_id[16:0], rx_bit};
          S_RTR:   rx_rtr <= rx_bit;
          default: rx_id <= rx_id;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acceptance_filter.sv
// Bench for acceptance_filter: directed scenarios plus random frames vs a model.
// Build with +define+ACCF_RTR_FILTER_EN to match an RTR-filtering DUT.
module tb_acceptance_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sof = 1'b0;
  logic        bit_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic        rx_ok = 1'b0;
  logic        rx_err = 1'b0;
  logic [15:0] acccode1 = '0;
  logic [15:0] acccode2 = '0;
  logic [15:0] accmask1 = '0;
  logic [15:0] accmask2 = '0;
  logic        accept;
  logic [28:0] rx_id;
  logic        rx_ide;
  logic        rx_rtr;
  logic        filt_busy;

  int checks = 0;
  int failures = 0;

  acceptance_filter dut (
    .clk(clk), .rst(rst), .sof(sof), .bit_valid(bit_valid),
    .rx_bit(rx_bit), .rx_ok(rx_ok), .rx_err(rx_err),
    .acccode1(acccode1), .acccode2(acccode2),
    .accmask1(accmask1), .accmask2(accmask2),
    .accept(accept), .rx_id(rx_id), .rx_ide(rx_ide),
    .rx_rtr(rx_rtr), .filt_busy(filt_busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b, input bit gaps);
    bit_valid = 1'b1;
    rx_bit = b;
    cyc();
    bit_valid = 1'b0;
    rx_bit = 1'($urandom);
    if (gaps) repeat ($urandom_range(0, 2)) cyc();
  endtask

  // id holds the 11-bit value in [10:0] for standard frames.
  task automatic send_bits(input logic ide, input logic [28:0] id,
                           input logic rtr, input bit gaps);
    for (int i = 10; i >= 0; i--)
      put_bit(ide ? id[18+i] : id[i], gaps);
    put_bit(ide ? 1'b1 : rtr, gaps);
    put_bit(ide, gaps);
    if (ide) begin
      for (int i = 17; i >= 0; i--)
        put_bit(id[i], gaps);
      put_bit(rtr, gaps);
    end
  endtask

  task automatic send_hdr(input logic ide, input logic [28:0] id,
                          input logic rtr, input bit gaps);
    sof = 1'b1;
    bit_valid = 1'b1;
    rx_bit = 1'b1;
    cyc();
    sof = 1'b0;
    bit_valid = 1'b0;
    send_bits(ide, id, rtr, gaps);
  endtask

  task automatic set_regs(input logic [28:0] c, input logic crtr,
                          input logic [28:0] m, input logic mrtr);
    acccode1 = c[15:0];
    acccode2 = {2'($urandom), crtr, c[28:16]};
    accmask1 = m[15:0];
    accmask2 = {2'($urandom), mrtr, m[28:16]};
  endtask

  function automatic logic [28:0] exp_id(input logic ide, input logic [28:0] id);
    return ide ? id : {id[10:0], 18'd0};
  endfunction

  // Bitwise walk: a bit counts when masked and (extended or in the base field).
  function automatic logic exp_acc(input logic ide, input logic [28:0] id,
                                   input logic rtr);
    logic [28:0] rid;
    logic [28:0] c;
    logic [28:0] m;
    rid = exp_id(ide, id);
    c = {acccode2[12:0], acccode1};
    m = {accmask2[12:0], accmask1};
    for (int i = 0; i < 29; i++)
      if (m[i] && (ide || i >= 18) && (c[i] != rid[i]))
        return 1'b0;
`ifdef ACCF_RTR_FILTER_EN
    if (accmask2[13] && (acccode2[13] != rtr))
      return 1'b0;
`else
    if (rtr === 1'bx) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    checks++;
    if (accept !== 1'b0 || rx_id !== 29'd0 || rx_ide !== 1'b0 ||
        rx_rtr !== 1'b0 || filt_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: acc=%0b id=%0h ide=%0b rtr=%0b busy=%0b want all 0",
               accept, rx_id, rx_ide, rx_rtr, filt_busy);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_std();
    set_regs(29'h123 << 18, 1'b0, 29'h1FFFFFFF, 1'b0);
    sof = 1'b1;
    cyc();
    sof = 1'b0;
    checks++;
    if (filt_busy !== 1'b1) begin
      failures++;
      $display("FAIL std_busy got=%0b want=1", filt_busy);
    end
    send_bits(1'b0, 29'h123, 1'b0, 1'b0);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b1) begin
      failures++;
      $display("FAIL std_accept got=%0b want=1", accept);
    end
    checks++;
    if (rx_id !== (29'h123 << 18) || rx_ide !== 1'b0) begin
      failures++;
      $display("FAIL std_fields id=%0h ide=%0b want id=%0h ide=0",
               rx_id, rx_ide, 29'h123 << 18);
    end
    cyc();
    checks++;
    if (accept !== 1'b0) begin
      failures++;
      $display("FAIL std_pulse got=%0b want=0", accept);
    end
  endtask

  task automatic test_ext();
    set_regs(29'h1ABCDEF1, 1'b0, 29'h1FFFFFFE, 1'b0);
    send_hdr(1'b1, 29'h1ABCDEF0, 1'b0, 1'b1);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b1 || rx_id !== 29'h1ABCDEF0 || rx_ide !== 1'b1) begin
      failures++;
      $display("FAIL ext_match acc=%0b id=%0h ide=%0b want 1/1abcdef0/1",
               accept, rx_id, rx_ide);
    end
    set_regs(29'h1ABCDEF1, 1'b0, 29'h1FFFFFFF, 1'b0);
    send_hdr(1'b1, 29'h1ABCDEF0, 1'b0, 1'b0);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b0) begin
      failures++;
      $display("FAIL ext_nomatch got=%0b want=0", accept);
    end
  endtask

  task automatic test_rx_err();
    set_regs('0, 1'b0, '0, 1'b0);
    send_hdr(1'b1, 29'h0F0F0F0F, 1'b1, 1'b0);
    rx_err = 1'b1;
    cyc();
    rx_err = 1'b0;
    checks++;
    if (accept !== 1'b0 || filt_busy !== 1'b0) begin
      failures++;
      $display("FAIL rx_err acc=%0b busy=%0b want 0/0", accept, filt_busy);
    end
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b0) begin
      failures++;
      $display("FAIL rx_ok_idle got=%0b want=0", accept);
    end
  endtask

  task automatic test_restart();
    set_regs('0, 1'b0, '0, 1'b0);
    sof = 1'b1;
    cyc();
    sof = 1'b0;
    for (int i = 0; i < 5; i++) put_bit(1'b0, 1'b0);
    send_hdr(1'b0, 29'h7FF, 1'b0, 1'b0);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b1 || rx_id !== (29'h7FF << 18)) begin
      failures++;
      $display("FAIL restart acc=%0b id=%0h want 1/%0h", accept, rx_id,
               29'h7FF << 18);
    end
  endtask

  task automatic test_truncated();
    set_regs('0, 1'b0, '0, 1'b0);
    sof = 1'b1;
    cyc();
    sof = 1'b0;
    for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b0 || filt_busy !== 1'b0) begin
      failures++;
      $display("FAIL truncated acc=%0b busy=%0b want 0/0", accept, filt_busy);
    end
  endtask

  task automatic test_reset_mid();
    set_regs('0, 1'b0, '0, 1'b0);
    sof = 1'b1;
    cyc();
    sof = 1'b0;
    for (int i = 0; i < 11; i++) put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) put_bit(1'b1, 1'b0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    checks++;
    if (accept !== 1'b0 || rx_id !== 29'd0 || rx_ide !== 1'b0 ||
        rx_rtr !== 1'b0 || filt_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid acc=%0b id=%0h ide=%0b rtr=%0b busy=%0b want 0",
               accept, rx_id, rx_ide, rx_rtr, filt_busy);
    end
    set_regs(29'h2AA << 18, 1'b0, 29'h1FFC0000, 1'b0);
    send_hdr(1'b0, 29'h2AA, 1'b0, 1'b1);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b1 || rx_id !== (29'h2AA << 18)) begin
      failures++;
      $display("FAIL after_reset acc=%0b id=%0h want 1/%0h", accept, rx_id,
               29'h2AA << 18);
    end
  endtask

  task automatic test_rtr();
    logic want;
    set_regs(29'h055 << 18, 1'b0, 29'h1FFFFFFF, 1'b1);
`ifdef ACCF_RTR_FILTER_EN
    want = 1'b0;
`else
    want = 1'b1;
`endif
    send_hdr(1'b0, 29'h055, 1'b1, 1'b0);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== want || rx_rtr !== 1'b1) begin
      failures++;
      $display("FAIL rtr acc=%0b rtr=%0b want %0b/1", accept, rx_rtr, want);
    end
  endtask

  task automatic test_back_to_back();
    set_regs(29'h3C3 << 18, 1'b0, 29'h1FFC0000, 1'b0);
    send_hdr(1'b0, 29'h3C3, 1'b0, 1'b0);
    rx_ok = 1'b1;
    sof = 1'b1;
    cyc();
    rx_ok = 1'b0;
    sof = 1'b0;
    checks++;
    if (accept !== 1'b1 || filt_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first acc=%0b busy=%0b want 1/1", accept, filt_busy);
    end
    set_regs(29'h0ABCDE12, 1'b0, 29'h1FFFFFFF, 1'b0);
    send_bits(1'b1, 29'h0ABCDE12, 1'b0, 1'b0);
    rx_ok = 1'b1;
    cyc();
    rx_ok = 1'b0;
    checks++;
    if (accept !== 1'b1 || rx_id !== 29'h0ABCDE12) begin
      failures++;
      $display("FAIL b2b_second acc=%0b id=%0h want 1/abcde12", accept, rx_id);
    end
  endtask

  task automatic test_random();
    logic        ide;
    logic        rtr;
    logic [28:0] id;
    logic [28:0] rid;
    logic [28:0] c;
    logic [28:0] m;
    logic        want;
    for (int n = 0; n < 40; n++) begin
      ide = 1'($urandom);
      rtr = 1'($urandom);
      id  = 29'($urandom);
      if (!ide) id = {18'd0, id[10:0]};
      rid = exp_id(ide, id);
      set_regs(29'($urandom), 1'($urandom), 29'($urandom), 1'($urandom));
      send_hdr(ide, id, rtr, 1'b1);
      m = 29'($urandom);
      c = ($urandom_range(0, 2) != 0) ? rid ^ (29'd1 << $urandom_range(0, 28)) & ~m
                                      : 29'($urandom);
      if ($urandom_range(0, 3) == 0) m = '0;
      set_regs(c, 1'($urandom), m, 1'($urandom));
      want = exp_acc(ide, id, rtr);
      repeat ($urandom_range(0, 2)) cyc();
      rx_ok = 1'b1;
      cyc();
      rx_ok = 1'b0;
      checks++;
      if (accept !== want || rx_id !== rid || rx_ide !== ide ||
          rx_rtr !== rtr || filt_busy !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d acc=%0b id=%0h ide=%0b rtr=%0b busy=%0b want %0b/%0h/%0b/%0b/0",
                 n, accept, rx_id, rx_ide, rx_rtr, filt_busy, want, rid, ide, rtr);
      end
      cyc();
      checks++;
      if (accept !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_pulse got=%0b want=0", n, accept);
      end
    end
  endtask

  initial begin
    test_reset();
    test_std();
    test_ext();
    test_rx_err();
    test_restart();
    test_truncated();
    test_reset_mid();
    test_rtr();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
